// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM for the MIPS-subset CPU.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, selects the PC
// source, counts retired instructions and halts on a stalled memory.
module pc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_rd,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;
  logic              w_retire;
  logic              w_stall;
  logic              w_timeout;

  logic w_is_r, w_is_jr, w_is_j, w_is_jal, w_is_beq, w_is_bne;
  logic w_is_lw, w_is_sw, w_is_addi, w_is_xori, w_to_exec;

  assign w_is_r    = (opcode == 6'h00);
  assign w_is_jr   = w_is_r && (funct == 6'h08);
  assign w_is_j    = (opcode == 6'h02);
  assign w_is_jal  = (opcode == 6'h03);
  assign w_is_beq  = (opcode == 6'h04);
  assign w_is_bne  = (opcode == 6'h05);
  assign w_is_lw   = (opcode == 6'h23);
  assign w_is_sw   = (opcode == 6'h2b);
  assign w_is_addi = (opcode == 6'h08);
  assign w_is_xori = (opcode == 6'h0e);
  assign w_to_exec = (w_is_r && !w_is_jr) || w_is_beq || w_is_bne ||
                     w_is_lw || w_is_sw || w_is_addi || w_is_xori;

  // A stall cycle is a waiting state whose memory has not answered yet.
  assign w_stall   = ((r_state == S_FETCH) && !imem_ready) ||
                     ((r_state == S_MEM) && !dmem_ready);
  assign w_timeout = w_stall && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state selection and retire strobe.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_ready)     w_next = S_DECODE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_DECODE: begin
        if (w_is_j || w_is_jal || w_is_jr) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_to_exec) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        if (w_is_beq || w_is_bne) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (w_is_lw) begin
            w_next = S_WB;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // State, stall counter and retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      // Any non-stall cycle (ready seen or a non-waiting state) clears the
      // counter, which also covers clearing on entry to FETCH/MEM.
      if (w_stall) r_wait <= r_wait + WAIT_W'(1);
      else         r_wait <= '0;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Control outputs decoded from state and the current instruction.
  always_comb begin
    imem_rd = 1'b0;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    pc_src  = 2'b00;
    dmem_rd = 1'b0;
    dmem_wr = 1'b0;
    reg_wr  = 1'b0;
    reg_dst = 2'b00;
    alu_op  = 3'b000;
    illegal = 1'b0;
    halted  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          imem_rd = 1'b1;
          if (imem_ready) begin
            ir_wr = 1'b1;
            pc_wr = 1'b1;
          end
        end
        S_DECODE: begin
          if (w_is_j || w_is_jal) begin
            pc_wr  = 1'b1;
            pc_src = 2'b10;
            if (w_is_jal) begin
              reg_wr  = 1'b1;
              reg_dst = 2'b10;
            end
          end else if (w_is_jr) begin
            pc_wr  = 1'b1;
            pc_src = 2'b11;
          end else if (!w_to_exec) begin
            illegal = 1'b1;
          end
        end
        S_EXEC: begin
          if (w_is_r)                     alu_op = 3'b010;
          else if (w_is_beq || w_is_bne)  alu_op = 3'b001;
          else if (w_is_xori)             alu_op = 3'b011;
          if (w_is_beq) begin
            pc_wr  = zero;
            pc_src = 2'b01;
          end else if (w_is_bne) begin
            pc_wr  = ~zero;
            pc_src = 2'b01;
          end
        end
        S_MEM: begin
          dmem_rd = w_is_lw;
          dmem_wr = w_is_sw;
        end
        S_WB: begin
          reg_wr  = 1'b1;
          reg_dst = w_is_r ? 2'b01 : 2'b00;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized checks of pc_sequencer against a phase-list
// model that expands each instruction into its expected per-cycle outputs.
module tb_pc_sequencer;
  localparam int unsigned MT = 16;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic       imem_rd;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       dmem_rd;
    logic       dmem_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
    logic       illegal;
    logic       halted;
  } outs_t;

  typedef struct {
    logic  ir;
    logic  dr;
    outs_t e;
  } step_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          imem_rd, ir_wr, pc_wr, dmem_rd, dmem_wr, reg_wr, illegal, halted;
  logic [1:0]    pc_src, reg_dst;
  logic [2:0]    alu_op;
  logic [CW-1:0] retired;

  int    total = 0;
  int    bad = 0;
  int    m_ret = 0;
  int    m_rflag = 0;
  step_t q[$];
  logic [5:0] g_op, g_fn;
  logic       g_z;

  always #5 clk = ~clk;

  pc_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_rd(imem_rd),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst), .alu_op(alu_op),
    .illegal(illegal), .halted(halted), .retired(retired)
  );

  function automatic outs_t dut_outs();
    outs_t o;
    o.imem_rd = imem_rd; o.ir_wr = ir_wr; o.pc_wr = pc_wr; o.pc_src = pc_src;
    o.dmem_rd = dmem_rd; o.dmem_wr = dmem_wr; o.reg_wr = reg_wr;
    o.reg_dst = reg_dst; o.alu_op = alu_op; o.illegal = illegal; o.halted = halted;
    return o;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input outs_t e, input logic ir, input logic dr);
    step_t s;
    s.ir = ir; s.dr = dr; s.e = e;
    q.push_back(s);
  endtask

  task automatic halt_tail();
    outs_t e;
    for (int i = 0; i < 4; i++) begin
      e = '0; e.halted = 1'b1;
      push(e, rb(), rb());
    end
  endtask

  // Expand one instruction into its expected cycle list from the ISA rules.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fwait, input int mwait);
    outs_t e;
    logic is_jump, is_exec, is_br, is_mem;
    q.delete();
    m_rflag = 0;
    g_op = op; g_fn = fn; g_z = z;
    for (int i = 0; i < fwait && i < MT; i++) begin
      e = '0; e.imem_rd = 1'b1;
      push(e, 1'b0, rb());
    end
    if (fwait >= MT) begin halt_tail(); return; end
    e = '0; e.imem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
    push(e, 1'b1, rb());
    is_jump = (op == 6'h02) || (op == 6'h03) || (op == 6'h00 && fn == 6'h08);
    is_exec = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h23) ||
              (op == 6'h2b) || (op == 6'h08) || (op == 6'h0e);
    is_br   = (op == 6'h04) || (op == 6'h05);
    is_mem  = (op == 6'h23) || (op == 6'h2b);
    e = '0;
    if (is_jump) begin
      e.pc_wr  = 1'b1;
      e.pc_src = (op == 6'h00) ? 2'b11 : 2'b10;
      if (op == 6'h03) begin e.reg_wr = 1'b1; e.reg_dst = 2'b10; end
      push(e, rb(), rb());
      m_rflag = 1;
      return;
    end
    if (!is_exec) begin
      e.illegal = 1'b1;
      push(e, rb(), rb());
      return;
    end
    push(e, rb(), rb());
    e = '0;
    e.alu_op = (op == 6'h00) ? 3'd2 : is_br ? 3'd1 : (op == 6'h0e) ? 3'd3 : 3'd0;
    if (is_br) begin
      e.pc_src = 2'b01;
      e.pc_wr  = (op == 6'h04) ? z : !z;
      push(e, rb(), rb());
      m_rflag = 1;
      return;
    end
    push(e, rb(), rb());
    if (is_mem) begin
      e = '0;
      if (op == 6'h23) e.dmem_rd = 1'b1; else e.dmem_wr = 1'b1;
      for (int i = 0; i < mwait && i < MT; i++) push(e, rb(), 1'b0);
      if (mwait >= MT) begin halt_tail(); return; end
      push(e, rb(), 1'b1);
      if (op == 6'h2b) begin m_rflag = 1; return; end
    end
    e = '0; e.reg_wr = 1'b1; e.reg_dst = (op == 6'h00) ? 2'b01 : 2'b00;
    push(e, rb(), rb());
    m_rflag = 1;
  endtask

  // Play the modelled cycles; n < 0 plays all of them and commits the retire.
  task automatic run_steps(input string nm, input int n);
    outs_t got;
    for (int k = 0; k < q.size(); k++) begin
      if (n >= 0 && k >= n) break;
      @(negedge clk);
      reset = 1'b0;
      if (k == 0) begin opcode = g_op; funct = g_fn; zero = g_z; end
      imem_ready = q[k].ir;
      dmem_ready = q[k].dr;
      #1;
      if (k == 0) begin
        total++;
        if (retired !== m_ret[CW-1:0]) begin
          bad++;
          $display("FAIL %s retired_at_start: got %0d want %0d", nm, retired, m_ret[CW-1:0]);
        end
      end
      got = dut_outs();
      total++;
      if (got !== q[k].e) begin
        bad++;
        $display("FAIL %s step%0d outs: got %b want %b", nm, k, got, q[k].e);
      end
    end
    if (n < 0) m_ret = (m_ret + m_rflag) % (1 << CW);
  endtask

  task automatic exec_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fwait, input int mwait);
    model_instr(op, fn, z, fwait, mwait);
    run_steps(nm, -1);
  endtask

  task automatic do_reset(input string nm);
    outs_t got;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b1;
      imem_ready = rb(); dmem_ready = rb();
      opcode = 6'($urandom); funct = 6'($urandom); zero = rb();
      #1;
      got = dut_outs();
      total++;
      if (got !== '0) begin
        bad++;
        $display("FAIL %s outs_in_reset: got %b want 0", nm, got);
      end
      if (c == 1) begin
        total++;
        if (retired !== '0) begin
          bad++;
          $display("FAIL %s retired_in_reset: got %0d want 0", nm, retired);
        end
      end
    end
    m_ret = 0;
  endtask

  task automatic test_reset();        do_reset("reset"); endtask

  task automatic test_rtype();
    exec_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
    exec_instr("addi", 6'h08, 6'h11, 1'b1, 1, 0);
    exec_instr("xori", 6'h0e, 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_branch();
    exec_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
    exec_instr("beq_not", 6'h04, 6'h00, 1'b0, 0, 0);
    exec_instr("bne_taken", 6'h05, 6'h00, 1'b0, 0, 0);
    exec_instr("bne_not", 6'h05, 6'h00, 1'b1, 2, 0);
  endtask

  task automatic test_mem();
    exec_instr("lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3);
    exec_instr("sw_wait2", 6'h2b, 6'h00, 1'b0, 0, 2);
    exec_instr("lw_nowait", 6'h23, 6'h00, 1'b0, 0, 0);
    exec_instr("sw_wait15", 6'h2b, 6'h00, 1'b0, 0, MT - 1);
  endtask

  task automatic test_jumps();
    exec_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0);
    exec_instr("j", 6'h02, 6'h00, 1'b0, 0, 0);
    exec_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    exec_instr("illegal_3f", 6'h3f, 6'h00, 1'b0, 0, 0);
    exec_instr("illegal_01", 6'h01, 6'h08, 1'b1, 0, 0);
  endtask

  task automatic test_fetch_timeout();
    exec_instr("fetch_wait15", 6'h00, 6'h22, 1'b0, MT - 1, 0);
    exec_instr("fetch_wait16", 6'h00, 6'h20, 1'b0, MT, 0);
    do_reset("reset_from_halt");
    exec_instr("after_halt_j", 6'h02, 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_mem_timeout();
    exec_instr("lw_wait16", 6'h23, 6'h00, 1'b0, 0, MT);
    do_reset("reset_after_mem_halt");
  endtask

  task automatic test_reset_mid_mem();
    model_instr(6'h23, 6'h00, 1'b0, 0, 10);
    run_steps("lw_partial", 5);
    do_reset("reset_mid_mem");
    exec_instr("after_mid_reset_lw", 6'h23, 6'h00, 1'b0, 0, 1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) exec_instr("wrap_j", 6'h02, 6'($urandom), 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[11];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h08, 6'h0e, 6'h3f};
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 10)];
      if (op == 6'h3f) op = 6'($urandom);
      fn = ($urandom_range(0, 5) == 0) ? 6'h08 : 6'($urandom);
      exec_instr("random", op, fn, rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                 $urandom_range(0, 5));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_mem();
    test_jumps();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_reset_mid_mem();
    test_wrap();
    test_back_to_back();
    @(negedge clk);
    #1;
    total++;
    if (retired !== m_ret[CW-1:0]) begin
      bad++;
      $display("FAIL final_retired: got %0d want %0d", retired, m_ret[CW-1:0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
